ascon_perm_sched: RTL and testbench
===================================

Name: ascon_perm_sched

Overview:
- Sequences the masked, bit-sliced Ascon permutation datapath: each round is constant addition, then a PAR-bit-per-cycle masked S-box sweep, then the linear layer.
- Each S-box slice consumes fresh randomness through a valid/ready handshake with the LFSR source; the sweep stalls when randomness is unavailable.
- Sits between the Ascon-128a mode FSM (start/done) and the share-parallel permutation datapath.

Parameters:
- PAR, 6, state bits per share processed per S-box cycle (matches the package PAR).
- WORD_SIZE, 64, lane width in bits.
- NUM_SLICES, derived = (WORD_SIZE+PAR-1)/PAR = 11, randomness-consuming S-box cycles per round.
- SLICE_W, derived = $clog2(NUM_SLICES+1) = 4, slice index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- rounds_sel_i  in  1  0 = 12 rounds (p^a), 1 = 8 rounds (p^b); latched at start.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- rand_valid_i  in  1  fresh randomness (RAND_WIDTH bits) is available.
- rand_ready_o  out  1  randomness consumed this cycle when high together with rand_valid_i.
- const_add_o  out  1  datapath applies rc_o to lane x2 this cycle.
- rc_o  out  8  round constant.
- sbox_en_o  out  1  datapath advances its S-box pipeline this cycle.
- slice_idx_o  out  SLICE_W  current slice; NUM_SLICES marks the drain cycle.
- slice_mask_o  out  PAR  valid-bit mask for the current slice.
- linear_en_o  out  1  datapath applies the linear diffusion layer this cycle.

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and the round/slice counters are 0. A reset asserted mid-permutation aborts immediately and produces no done_o.
- States and transitions: IDLE -> CONST -> SBOX -> LINEAR -> (CONST | DONE) -> IDLE.
- IDLE: when start_i=1, latch rounds_sel_i and set the round counter r to 0 for 12 rounds or 4 for 8 rounds; go to CONST. start_i in any other state is ignored.
- CONST (1 cycle): const_add_o=1 and rc_o = {4'(15-r), 4'(r)}, so r=0 gives 0xF0, r=4 gives 0xB4, r=11 gives 0x4B. rc_o is 0 outside CONST.
- SBOX, slice cycles (slice_idx < NUM_SLICES):
  - rand_ready_o=1 and sbox_en_o = rand_valid_i.
  - The slice index increments only on a handshake; with rand_valid_i=0 all outputs hold.
  - slice_mask_o is all ones, except on the last slice where it is the low (WORD_SIZE % PAR) bits, i.e. 6'b001111 (all ones if the remainder is 0).
- SBOX, drain cycle (slice_idx = NUM_SLICES): exactly 1 cycle; sbox_en_o=1, rand_ready_o=0, slice_mask_o=0. rand_valid_i is ignored. Then go to LINEAR with slice_idx reset to 0.
- LINEAR (1 cycle): linear_en_o=1. If r=11 go to DONE, otherwise r++ and go to CONST.
- DONE (1 cycle): done_o=1 and busy_o=1, then IDLE. A new start is accepted on the cycle after DONE at the earliest.
- Timing without stalls: a round is 1+NUM_SLICES+1+1 = 14 cycles. With start sampled at edge 0, done_o is high in cycle 14·R+1 (169 for 12 rounds, 113 for 8 rounds). Each stall cycle adds exactly 1.
- Control outputs are registered-state decodes. Only sbox_en_o in slice cycles depends combinationally on rand_valid_i.

Optional Feature:
- Macro: ASCON_PERM_SCHED_STALL_CNT_EN.
- When defined, adds the output stall_cnt_o [15:0]:
  - counts SBOX slice cycles with rand_ready_o=1 and rand_valid_i=0;
  - saturates at 16'hFFFF;
  - clears to 0 on an accepted start and on reset;
  - holds its value after done.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- 12 rounds, rand_valid_i=1 throughout, start at cycle 0 -> rc_o in CONST cycles F0,E1,D2,…,4B; done_o pulse only in cycle 169; 132 handshakes total.
- rounds_sel_i=1 -> first rc 0xB4, last 0x4B; done_o in cycle 113; busy_o low in cycle 114.
- rand_valid_i=0 for 3 cycles while slice_idx_o=5 in round 0 -> slice_idx_o holds 5 and sbox_en_o=0 for those cycles; done_o in cycle 172; stall_cnt_o=3 when the macro is enabled.
- Observe each slice in round 0 -> slice_mask_o=6'b111111 for idx 0..9, 6'b001111 for idx 10, 0 on the drain cycle (idx 11) with rand_ready_o=0 even though rand_valid_i=1.
- start_i pulsed at cycle 50 while busy -> ignored; done timing unchanged; exactly one done_o pulse.
- rst_n low at cycle 45 (round 3) -> all outputs 0 asynchronously, no done_o; a fresh start afterwards completes normally in 169 cycles.

Source files
------------

// File: rtl/ascon_perm_sched_if.sv
// Control bundle between the Ascon permutation scheduler, the mode FSM,
// the randomness source and the masked datapath.
interface ascon_perm_sched_if #(
  parameter int PAR     = 6,
  parameter int SLICE_W = 4
) ();
  logic               start_i;
  logic               rounds_sel_i;
  logic               busy_o;
  logic               done_o;
  logic               rand_valid_i;
  logic               rand_ready_o;
  logic               const_add_o;
  logic [7:0]         rc_o;
  logic               sbox_en_o;
  logic [SLICE_W-1:0] slice_idx_o;
  logic [PAR-1:0]     slice_mask_o;
  logic               linear_en_o;

  modport slave (
    input  start_i, rounds_sel_i, rand_valid_i,
    output busy_o, done_o, rand_ready_o, const_add_o, rc_o,
           sbox_en_o, slice_idx_o, slice_mask_o, linear_en_o
  );

  modport master (
    output start_i, rounds_sel_i, rand_valid_i,
    input  busy_o, done_o, rand_ready_o, const_add_o, rc_o,
           sbox_en_o, slice_idx_o, slice_mask_o, linear_en_o
  );
endinterface

// File: rtl/ascon_perm_sched.sv
// Round/slice sequencer for the masked bit-sliced Ascon permutation.
// Optional stall counter output enabled by ASCON_PERM_SCHED_STALL_CNT_EN.
module ascon_perm_sched #(
  parameter int PAR       = 6,
  parameter int WORD_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ascon_perm_sched_if.slave    bus
`ifdef ASCON_PERM_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt_o
`endif
);
  localparam int NUM_SLICES = (WORD_SIZE + PAR - 1) / PAR;
  localparam int SLICE_W    = $clog2(NUM_SLICES + 1);
  localparam int LAST_REM   = WORD_SIZE % PAR;
  localparam logic [SLICE_W-1:0] SLICE_DRAIN = SLICE_W'(NUM_SLICES);
  localparam logic [SLICE_W-1:0] SLICE_FINAL = SLICE_W'(NUM_SLICES - 1);
  localparam logic [PAR-1:0]     LAST_MASK   =
    (LAST_REM == 0) ? {PAR{1'b1}} : PAR'((1 << LAST_REM) - 1);
  localparam logic [3:0] ROUND_LAST = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE, S_CONST, S_SBOX, S_LINEAR, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         round_q, round_d;
  logic [SLICE_W-1:0] slice_q, slice_d;

  logic               busy, done, rand_ready, const_add, sbox_en, linear_en;
  logic [7:0]         rc;
  logic [PAR-1:0]     mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      round_q <= '0;
      slice_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      slice_q <= slice_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    slice_d    = slice_q;
    busy       = 1'b0;
    done       = 1'b0;
    rand_ready = 1'b0;
    const_add  = 1'b0;
    sbox_en    = 1'b0;
    linear_en  = 1'b0;
    rc         = '0;
    mask       = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          // p^b runs the last 8 of the 12 round constants
          round_d = bus.rounds_sel_i ? 4'd4 : 4'd0;
          slice_d = '0;
          state_d = S_CONST;
        end
      end
      S_CONST: begin
        busy      = 1'b1;
        const_add = 1'b1;
        rc        = {4'd15 - round_q, round_q};
        state_d   = S_SBOX;
      end
      S_SBOX: begin
        busy = 1'b1;
        if (slice_q != SLICE_DRAIN) begin
          rand_ready = 1'b1;
          sbox_en    = bus.rand_valid_i;
          mask       = (slice_q == SLICE_FINAL) ? LAST_MASK : {PAR{1'b1}};
          if (bus.rand_valid_i) slice_d = slice_q + SLICE_W'(1);
        end else begin
          // drain cycle flushes the S-box pipeline without consuming randomness
          sbox_en = 1'b1;
          slice_d = '0;
          state_d = S_LINEAR;
        end
      end
      S_LINEAR: begin
        busy      = 1'b1;
        linear_en = 1'b1;
        if (round_q == ROUND_LAST) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = S_CONST;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy_o       = busy;
  assign bus.done_o       = done;
  assign bus.rand_ready_o = rand_ready;
  assign bus.const_add_o  = const_add;
  assign bus.rc_o         = rc;
  assign bus.sbox_en_o    = sbox_en;
  assign bus.slice_idx_o  = slice_q;
  assign bus.slice_mask_o = mask;
  assign bus.linear_en_o  = linear_en;

`ifdef ASCON_PERM_SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && bus.start_i) begin
      stall_d = '0;
    end else if (rand_ready && !bus.rand_valid_i && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif
endmodule

// File: tb/tb_ascon_perm_sched.sv
// Directed self-checking bench for ascon_perm_sched (12/8 rounds, stalls,
// masks, ignored start, mid-run reset).
module tb_ascon_perm_sched;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  ascon_perm_sched_if #(.PAR(6), .SLICE_W(4)) bus ();

`ifdef ASCON_PERM_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
  ascon_perm_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt_o(stall_cnt));
`else
  ascon_perm_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.busy_o), 0);
    check({tag, "_done"},  32'(bus.done_o), 0);
    check({tag, "_rdy"},   32'(bus.rand_ready_o), 0);
    check({tag, "_cadd"},  32'(bus.const_add_o), 0);
    check({tag, "_rc"},    32'(bus.rc_o), 0);
    check({tag, "_sbox"},  32'(bus.sbox_en_o), 0);
    check({tag, "_idx"},   32'(bus.slice_idx_o), 0);
    check({tag, "_mask"},  32'(bus.slice_mask_o), 0);
    check({tag, "_lin"},   32'(bus.linear_en_o), 0);
  endtask

  // Runs one permutation from IDLE; start is sampled at edge 0, so the
  // cycle after that edge is cycle 1.
  task automatic run_perm(input bit sel, input int exp_done, input int stall_at,
                          input int pulse_at, input bit chk_slices, input int exp_hs);
    int ri, nd, nhs, nconst, last_rc, exp_rc, idx;
    bit stalled;
    ri = sel ? 4 : 0;
    nd = 0; nhs = 0; nconst = 0; last_rc = 0;
    bus.start_i = 1'b1;
    bus.rounds_sel_i = sel;
    bus.rand_valid_i = 1'b1;
    cyc = 0;
    tick();
    bus.start_i = 1'b0;
    bus.rounds_sel_i = ~sel;
    while (cyc <= exp_done + 3) begin
      stalled = (stall_at > 0) && (cyc >= stall_at) && (cyc < stall_at + 3);
      bus.rand_valid_i = ~stalled;
      bus.start_i = (cyc == pulse_at);
      #1;
      check("done_pulse", 32'(bus.done_o), 32'(cyc == exp_done));
      check("busy", 32'(bus.busy_o), 32'(cyc <= exp_done));
      if (bus.done_o) nd++;
      if (bus.rand_ready_o && bus.rand_valid_i) nhs++;
      if (bus.const_add_o) begin
        exp_rc = ((15 - ri) << 4) | ri;
        check("rc", 32'(bus.rc_o), 32'(exp_rc));
        last_rc = 32'(bus.rc_o);
        ri++;
        nconst++;
      end
      if (chk_slices && cyc >= 2 && cyc <= 13) begin
        idx = cyc - 2;
        check("slice_idx", 32'(bus.slice_idx_o), 32'(idx));
        check("slice_mask", 32'(bus.slice_mask_o),
              (idx < 10) ? 32'h3F : (idx == 10) ? 32'h0F : 32'h00);
        check("slice_rdy", 32'(bus.rand_ready_o), 32'(idx < 11));
        check("slice_sbox_en", 32'(bus.sbox_en_o), 1);
      end
      if (stalled) begin
        check("stall_idx", 32'(bus.slice_idx_o), 5);
        check("stall_sbox_en", 32'(bus.sbox_en_o), 0);
        check("stall_rdy", 32'(bus.rand_ready_o), 1);
      end
      tick();
    end
    bus.start_i = 1'b0;
    bus.rand_valid_i = 1'b1;
    check("done_count", 32'(nd), 1);
    check("handshakes", 32'(nhs), 32'(exp_hs));
    check("const_cycles", 32'(nconst), sel ? 32'd8 : 32'd12);
    check("last_rc", 32'(last_rc), 32'h4B);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.rounds_sel_i = 1'b0;
    bus.rand_valid_i = 1'b1;
    #2;
    check_all_zero("reset");
`ifdef ASCON_PERM_SCHED_STALL_CNT_EN
    check("reset_stall_cnt", 32'(stall_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    // 12 rounds, no stalls, full slice sweep checked in round 0
    run_perm(1'b0, 169, 0, 0, 1'b1, 132);
`ifdef ASCON_PERM_SCHED_STALL_CNT_EN
    check("stall_cnt_none", 32'(stall_cnt), 0);
`endif

    // 8 rounds: first rc B4, last 4B, done at 113
    run_perm(1'b1, 113, 0, 0, 1'b0, 88);

    // three-cycle randomness stall at slice 5 of round 0
    run_perm(1'b0, 172, 7, 0, 1'b0, 132);
`ifdef ASCON_PERM_SCHED_STALL_CNT_EN
    check("stall_cnt_3", 32'(stall_cnt), 3);
`endif

    // start pulse while busy must be ignored
    run_perm(1'b0, 169, 0, 50, 1'b0, 132);
`ifdef ASCON_PERM_SCHED_STALL_CNT_EN
    check("stall_cnt_clear", 32'(stall_cnt), 0);
`endif

    // mid-run reset in round 3
    bus.start_i = 1'b1;
    bus.rounds_sel_i = 1'b0;
    cyc = 0;
    tick();
    bus.start_i = 1'b0;
    while (cyc < 45) tick();
    #1;
    check("pre_reset_busy", 32'(bus.busy_o), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_no_done", 32'(bus.done_o), 0);
    end
    rst_n = 1'b1;
    tick();
    tick();
    check("post_reset_busy", 32'(bus.busy_o), 0);
    run_perm(1'b0, 169, 0, 0, 1'b0, 132);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
